// File: rtl/rx_dmac_filter.sv
// Receive-path destination-MAC filter: forwards or drops whole AXI4-Stream frames based on the first beat.
// Optional per-frame pass/drop counters are compiled in with RX_DMAC_FILTER_STATS_EN.
module rx_dmac_filter (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic [47:0] mac_addr,
  input  logic        mcast_en,
  output logic [31:0] pass_cnt,
  output logic [31:0] drop_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_SOF  = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [63:0] m_data_q, m_data_d;
  logic [7:0]  m_keep_q, m_keep_d;
  logic        m_last_q, m_last_d;

  logic [47:0] dmac;
  logic        runt;
  logic        hit;
  logic        beat_acc;
  logic        fwd;

  // A beat moves on either port only when tvalid & tready are both high in the same cycle;
  // tvalid never waits on tready. Dropped beats bypass the output register, so DROP always accepts.
  assign s_axis_tready = (state_q == ST_DROP) || !m_valid_q || m_axis_tready;

  always_comb begin
    dmac     = s_axis_tdata[47:0];
    runt     = (s_axis_tkeep & 8'h3F) != 8'h3F;
    hit      = !runt && ((dmac == mac_addr) || (dmac == 48'hFFFF_FFFF_FFFF) ||
                         (mcast_en && dmac[0]));
    beat_acc = s_axis_tvalid && s_axis_tready;
    fwd      = beat_acc && (((state_q == ST_SOF) && hit) || (state_q == ST_PASS));

    state_d = state_q;
    case (state_q)
      ST_SOF: begin
        if (beat_acc && !s_axis_tlast) state_d = hit ? ST_PASS : ST_DROP;
      end
      ST_PASS, ST_DROP: begin
        if (beat_acc && s_axis_tlast) state_d = ST_SOF;
      end
      default: state_d = ST_SOF;
    endcase

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    if (fwd) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis_tdata;
      m_keep_d  = s_axis_tkeep;
      m_last_d  = s_axis_tlast;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= ST_SOF;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign dbg_state     = state_q;

`ifdef RX_DMAC_FILTER_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        pass_inc;
  logic        drop_inc;

  // Single-beat frames are classified and counted on their SOF beat.
  always_comb begin
    pass_inc   = beat_acc && s_axis_tlast &&
                 (((state_q == ST_SOF) && hit) || (state_q == ST_PASS));
    drop_inc   = beat_acc && s_axis_tlast &&
                 (((state_q == ST_SOF) && !hit) || (state_q == ST_DROP));
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pass_inc && (pass_cnt_q != 32'hFFFF_FFFF)) pass_cnt_d = pass_cnt_q + 32'd1;
    if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign pass_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_dmac_filter.sv
// Directed bench for rx_dmac_filter: frame driver, output monitor with expected-beat queue, final report.
module tb_rx_dmac_filter;

`ifdef RX_DMAC_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [47:0] MAC   = 48'h5544_3322_1100;
  localparam logic [47:0] OTHER = 48'h0000_0000_0002;
  localparam logic [47:0] MCAST = 48'h0000_5E00_0001;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  typedef logic [72:0] beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [47:0] mac_addr = MAC;
  logic        mcast_en = 1'b0;
  logic [31:0] pass_cnt;
  logic [31:0] drop_cnt;
  logic [1:0]  dbg_state;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned exp_pass_n = 0;
  int unsigned exp_drop_n = 0;
  bit          toggle_en = 1'b0;
  bit          prev_stall = 1'b0;
  beat_t       prev_beat = '0;
  beat_t       cur_beat;
  int          waits;

  rx_dmac_filter dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .mac_addr      (mac_addr),
    .mcast_en      (mcast_en),
    .pass_cnt      (pass_cnt),
    .drop_cnt      (drop_cnt),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (toggle_en) m_tready = ~m_tready;
  end

  task automatic check(input string tag, input beat_t obs, input beat_t exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // scoreboard: output handshakes are sampled mid-cycle and commit at the next posedge
  always @(negedge clk) begin
    cur_beat = {m_tlast, m_tkeep, m_tdata};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", beat_t'(m_tvalid), beat_t'(1));
        check("stall_hold", cur_beat, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat_q_depth", beat_t'(exp_q.size()), beat_t'(1));
        else check("out_beat", cur_beat, exp_q.pop_front());
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur_beat;
    end
  end

  // driver
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           output int w);
    w = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      w++;
      if (w > 200) begin
        check("tready_timeout", beat_t'(w), beat_t'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dmac, input int nb, input logic [7:0] keep0,
                            input bit pass, input bit lat, output int tw);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          w;
    tw = 0;
    for (int i = 0; i < nb; i++) begin
      d = (i == 0) ? {16'hBEEF, dmac} : {32'($urandom()), 32'($urandom())};
      k = (i == 0) ? keep0 : ((i == nb - 1) ? 8'h0F : 8'hFF);
      l = (i == nb - 1);
      if (pass) exp_q.push_back({l, k, d});
      send_beat(d, k, l, w);
      tw += w;
      if (lat) begin
        check("lat_valid", beat_t'(m_tvalid), beat_t'(1));
        check("lat_beat", {m_tlast, m_tkeep, m_tdata}, {l, k, d});
      end
    end
    if (pass) exp_pass_n++;
    else exp_drop_n++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) check("drain_timeout", beat_t'(n), beat_t'(0));
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_pass_cnt"}, beat_t'(pass_cnt), beat_t'(STATS ? exp_pass_n : 0));
    check({tag, "_drop_cnt"}, beat_t'(drop_cnt), beat_t'(STATS ? exp_drop_n : 0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", beat_t'(m_tvalid), beat_t'(0));
    check("rst_beat", {m_tlast, m_tkeep, m_tdata}, beat_t'(0));
    check("rst_state", beat_t'(dbg_state), beat_t'(0));
    check_cnts("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tready", beat_t'(s_tready), beat_t'(1));

    // station-address match, 1-cycle latency per beat
    send_frame(MAC, 3, 8'hFF, 1'b1, 1'b1, waits);
    drain();
    check("unicast_state", beat_t'(dbg_state), beat_t'(0));
    check_cnts("unicast");

    // no match: dropped without stalling even while downstream is not ready
    m_tready = 1'b0;
    send_frame(OTHER, 3, 8'hFF, 1'b0, 1'b0, waits);
    check("drop_no_stall", beat_t'(waits), beat_t'(0));
    check("drop_no_valid", beat_t'(m_tvalid), beat_t'(0));
    m_tready = 1'b1;
    check_cnts("drop");

    // multicast gated by mcast_en; broadcast always accepted
    send_frame(MCAST, 2, 8'hFF, 1'b0, 1'b0, waits);
    mcast_en = 1'b1;
    send_frame(MCAST, 2, 8'hFF, 1'b1, 1'b0, waits);
    mcast_en = 1'b0;
    send_frame(BCAST, 2, 8'hFF, 1'b1, 1'b0, waits);
    drain();
    check_cnts("mcast");

    // single-beat runt with matching address
    send_frame(MAC, 1, 8'h1F, 1'b0, 1'b0, waits);
    drain();
    check("runt_state", beat_t'(dbg_state), beat_t'(0));
    check_cnts("runt");

    // back-to-back frames with downstream ready toggling every cycle
    toggle_en = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(MAC, 4, 8'hFF, 1'b1, 1'b0, waits);
    toggle_en = 1'b0;
    m_tready = 1'b1;
    drain();
    check_cnts("toggle");

    // reset in the middle of a forwarded frame
    m_tready = 1'b0;
    send_beat({16'hBEEF, MAC}, 8'hFF, 1'b0, waits);
    check("pre_rst_state", beat_t'(dbg_state), beat_t'(1));
    rst_n = 1'b0;
    #1;
    exp_pass_n = 0;
    exp_drop_n = 0;
    check("midrst_tvalid", beat_t'(m_tvalid), beat_t'(0));
    check("midrst_beat", {m_tlast, m_tkeep, m_tdata}, beat_t'(0));
    check("midrst_state", beat_t'(dbg_state), beat_t'(0));
    check_cnts("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    send_frame(MAC, 3, 8'hFF, 1'b1, 1'b1, waits);
    drain();
    check_cnts("postrst");

    check("exp_q_empty", beat_t'(exp_q.size()), beat_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
